// File: rtl/operand_entry_if.sv
// Key-event and operand bus between the keypad scanner, operand_entry and the ALU/display stages.
interface operand_entry_if;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [7:0]  X;
    logic [7:0]  Y;
    logic        ops_valid;
    logic [15:0] preview;
    logic [2:0]  cursor;
    logic        key_err;
    logic        abort;

    modport master (
        output key_valid, key_code,
        input  X, Y, ops_valid, preview, cursor, key_err, abort
    );

    modport slave (
        input  key_valid, key_code,
        output X, Y, ops_valid, preview, cursor, key_err, abort
    );
endinterface

// File: rtl/operand_entry.sv
// Keypad operand-entry controller: assembles two hex bytes digit by digit and commits them
// atomically on ENTER, with BACK/CLEAR editing and an idle timeout that abandons partial entry.
module operand_entry #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic            clk,
    input  logic            clr_n,
    operand_entry_if.slave  op_if
);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [4:0] KEY_ENTER = 5'h10;
    localparam logic [4:0] KEY_BACK  = 5'h11;
    localparam logic [4:0] KEY_CLEAR = 5'h12;

    typedef enum logic [2:0] {
        X_HI = 3'd0,
        X_LO = 3'd1,
        Y_HI = 3'd2,
        Y_LO = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    xb_q, xb_d, yb_q, yb_d;
    logic [7:0]    x_q, x_d, y_q, y_d;
    logic          ops_valid_q, ops_valid_d;
    logic          key_err_q, key_err_d;
    logic          abort_q, abort_d;
    logic [TW-1:0] timer_q, timer_d;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        xb_d        = xb_q;
        yb_d        = yb_q;
        x_d         = x_q;
        y_d         = y_q;
        ops_valid_d = 1'b0;
        key_err_d   = 1'b0;
        abort_d     = 1'b0;
        timer_d     = '0;

        if (op_if.key_valid) begin
            if (!op_if.key_code[4]) begin
                unique case (state_q)
                    X_HI:    begin xb_d[7:4] = op_if.key_code[3:0]; state_d = X_LO; end
                    X_LO:    begin xb_d[3:0] = op_if.key_code[3:0]; state_d = Y_HI; end
                    Y_HI:    begin yb_d[7:4] = op_if.key_code[3:0]; state_d = Y_LO; end
                    Y_LO:    begin yb_d[3:0] = op_if.key_code[3:0]; state_d = DONE; end
                    default: key_err_d = 1'b1;
                endcase
            end else if (op_if.key_code == KEY_ENTER) begin
                if (state_q == DONE) begin
                    x_d         = xb_q;
                    y_d         = yb_q;
                    ops_valid_d = 1'b1;
                    xb_d        = '0;
                    yb_d        = '0;
                    state_d     = X_HI;
                end else begin
                    key_err_d = 1'b1;
                end
            end else if (op_if.key_code == KEY_BACK) begin
                // Undo the nibble that was written when the current state was entered.
                unique case (state_q)
                    X_LO:    begin xb_d[7:4] = 4'h0; state_d = X_HI; end
                    Y_HI:    begin xb_d[3:0] = 4'h0; state_d = X_LO; end
                    Y_LO:    begin yb_d[7:4] = 4'h0; state_d = Y_HI; end
                    DONE:    begin yb_d[3:0] = 4'h0; state_d = Y_LO; end
                    default: key_err_d = 1'b1;
                endcase
            end else if (op_if.key_code == KEY_CLEAR) begin
                xb_d    = '0;
                yb_d    = '0;
                state_d = X_HI;
            end else begin
                key_err_d = 1'b1;
            end
        end else if (state_q != X_HI) begin
            // A key in the expiry cycle wins, so abort is only reachable on an idle cycle.
            if (timer_q == TIMER_LAST) begin
                abort_d = 1'b1;
                xb_d    = '0;
                yb_d    = '0;
                state_d = X_HI;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q     <= X_HI;
            xb_q        <= '0;
            yb_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            ops_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            abort_q     <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            xb_q        <= xb_d;
            yb_q        <= yb_d;
            x_q         <= x_d;
            y_q         <= y_d;
            ops_valid_q <= ops_valid_d;
            key_err_q   <= key_err_d;
            abort_q     <= abort_d;
            timer_q     <= timer_d;
        end
    end

    assign op_if.X         = x_q;
    assign op_if.Y         = y_q;
    assign op_if.ops_valid = ops_valid_q;
    assign op_if.preview   = {xb_q, yb_q};
    assign op_if.cursor    = state_q;
    assign op_if.key_err   = key_err_q;
    assign op_if.abort     = abort_q;
endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: a digit-list model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_operand_entry;
    localparam int unsigned T = 8;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    operand_entry_if op_if ();

    operand_entry #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .op_if (op_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the entry is a list of up to four typed nibbles; cursor is the list length.
    int         m_len;
    logic [3:0] m_nib[4];
    logic [7:0] m_x, m_y;
    bit         m_ov, m_err, m_ab;
    int         m_idle;

    task automatic m_wipe();
        m_len = 0;
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    endtask

    always @(posedge clk) begin
        m_ov = 0; m_err = 0; m_ab = 0;
        if (!clr_n) begin
            m_wipe();
            m_x = 8'h00; m_y = 8'h00; m_idle = 0;
        end else if (op_if.key_valid) begin
            m_idle = 0;
            if (op_if.key_code < 5'h10) begin
                if (m_len == 4) m_err = 1;
                else begin m_nib[m_len] = op_if.key_code[3:0]; m_len++; end
            end else if (op_if.key_code == 5'h10) begin
                if (m_len == 4) begin
                    m_x = {m_nib[0], m_nib[1]};
                    m_y = {m_nib[2], m_nib[3]};
                    m_ov = 1;
                    m_wipe();
                end else m_err = 1;
            end else if (op_if.key_code == 5'h11) begin
                if (m_len == 0) m_err = 1;
                else begin m_len--; m_nib[m_len] = 4'h0; end
            end else if (op_if.key_code == 5'h12) begin
                m_wipe();
            end else m_err = 1;
        end else if (m_len != 0) begin
            m_idle++;
            if (m_idle == T) begin m_ab = 1; m_wipe(); m_idle = 0; end
        end else m_idle = 0;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model", {op_if.X, op_if.Y, op_if.preview, op_if.cursor,
                            op_if.ops_valid, op_if.key_err, op_if.abort},
                  {m_x, m_y, m_nib[0], m_nib[1], m_nib[2], m_nib[3], 3'(m_len),
                   m_ov, m_err, m_ab});
            check("pulse_excl", 64'(op_if.ops_valid + op_if.key_err + op_if.abort <= 1), 64'd1);
        end
    end

    // Caller is at a negedge; the key is sampled at the next rising edge and its effect
    // is visible when this task returns.
    task automatic key(input logic [4:0] code);
        op_if.key_valid = 1'b1;
        op_if.key_code  = code;
        @(negedge clk);
        op_if.key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        op_if.key_valid = 1'b0;
        op_if.key_code  = 5'h00;
        clr_n = 1'b0;
        idle(2);
        cmp_en = 1'b1;
        check("rst_state", {op_if.X, op_if.Y, op_if.preview, op_if.cursor}, 64'h0);
        check("rst_pulses", {op_if.ops_valid, op_if.key_err, op_if.abort}, 64'h0);
        clr_n = 1'b1;
        idle(1);

        // Basic entry and commit.
        key(5'h03); key(5'h0A); key(5'h05); key(5'h0C);
        check("entry_preview", op_if.preview, 64'h3A5C);
        check("entry_cursor", op_if.cursor, 64'd4);
        key(5'h10);
        check("commit_xy", {op_if.X, op_if.Y}, 64'h3A5C);
        check("commit_ov", op_if.ops_valid, 64'd1);
        check("commit_clr", {op_if.preview, op_if.cursor}, 64'h0);
        idle(1);
        check("ov_one_cycle", op_if.ops_valid, 64'd0);

        // ENTER too early, then CLEAR keeps committed operands.
        key(5'h01); key(5'h02); key(5'h10);
        check("early_enter_err", op_if.key_err, 64'd1);
        check("early_enter_cur", op_if.cursor, 64'd2);
        key(5'h03); key(5'h04); key(5'h12);
        check("clear_buf", {op_if.preview, op_if.cursor}, 64'h0);
        check("clear_keeps_xy", {op_if.X, op_if.Y}, 64'h3A5C);
        check("clear_no_err", op_if.key_err, 64'd0);

        // BACK editing.
        key(5'h01); key(5'h02); key(5'h03); key(5'h11);
        check("back_preview", op_if.preview, 64'h1200);
        check("back_cursor", op_if.cursor, 64'd2);
        key(5'h07); key(5'h04); key(5'h10);
        check("back_commit", {op_if.X, op_if.Y}, 64'h1274);
        key(5'h11);
        check("back_xhi_err", op_if.key_err, 64'd1);
        check("back_xhi_cur", op_if.cursor, 64'd0);
        key(5'h15);
        check("undef_err", op_if.key_err, 64'd1);

        // Timeout fires after T idle cycles.
        key(5'h0F);
        for (int i = 1; i < T; i++) begin
            idle(1);
            check("no_abort_yet", op_if.abort, 64'd0);
        end
        idle(1);
        check("abort_fires", op_if.abort, 64'd1);
        check("abort_clears", {op_if.preview, op_if.cursor}, 64'h0);
        check("abort_keeps_xy", {op_if.X, op_if.Y}, 64'h1274);
        idle(1);
        check("abort_one_cycle", op_if.abort, 64'd0);

        // Key on the expiry cycle wins.
        key(5'h0F);
        idle(T - 1);
        key(5'h05);
        check("race_no_abort", op_if.abort, 64'd0);
        check("race_key_taken", {op_if.preview, op_if.cursor}, {16'hF500, 3'd2});
        key(5'h12);

        // Back-to-back strobes; fifth digit rejected.
        for (int i = 0; i < 5; i++) begin
            op_if.key_valid = 1'b1;
            op_if.key_code  = 5'(i);
            @(negedge clk);
            if (i == 3) check("b2b_four", {op_if.preview, op_if.key_err}, {16'h0123, 1'b0});
        end
        op_if.key_valid = 1'b0;
        check("b2b_fifth_err", op_if.key_err, 64'd1);
        check("b2b_cursor", op_if.cursor, 64'd4);
        key(5'h12);

        // Reset mid-entry.
        key(5'h03); key(5'h0A); key(5'h05); key(5'h0C); key(5'h10);
        key(5'h01); key(5'h02); key(5'h03);
        check("pre_reset_cur", op_if.cursor, 64'd3);
        clr_n = 1'b0;
        idle(1);
        check("mid_reset", {op_if.X, op_if.Y, op_if.preview, op_if.cursor,
                            op_if.ops_valid, op_if.key_err, op_if.abort}, 64'h0);
        clr_n = 1'b1;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
